// File: rtl/stopwatch_bcd_pkg.sv
// ----------------------------------------------------------------------------
// stopwatch_bcd_pkg
// Shared definitions for the BCD stopwatch. It provides:
//   - the FSM state encoding
//   - the per-digit maximum values, indexed from centisecond units (0)
//     up to hour tens (7)
//   - the 23-hour terminal count that forces the hour pair to roll over
// ----------------------------------------------------------------------------
package stopwatch_bcd_pkg;

    // 2'd3 is never entered on purpose; the FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int unsigned NUM_DIGITS = 8;

    // Moduli, LSB digit first: cc units/tens (10/10), ss (10/6), mm (10/6).
    // The hour pair counts 0..9 / 0..2 and is cut short at 23 by HOUR_TC.
    localparam int unsigned DIGIT_MAX [NUM_DIGITS] = '{9, 9, 9, 5, 9, 5, 9, 2};

    localparam int unsigned HOUR_UNITS_IDX = 6;
    localparam logic [7:0]  HOUR_TC        = 8'h23;

endpackage

// File: rtl/stopwatch_bcd_digit_cnt.sv
// ----------------------------------------------------------------------------
// bcd_digit_cnt
// One BCD digit of the stopwatch cascade. It counts 0..MAX and advances on
// inc. It wraps to 0 when it is at MAX or when max_override is high.
//   clk, rst     : clock and synchronous active-high reset
//   clr          : synchronous clear; takes priority over inc
//   inc          : advance by one
//   max_override : treat the current value as terminal (hour 23 rollover)
//   q[3:0]       : current digit value
//   carry        : high when this digit wraps; drives the next digit's inc
// ----------------------------------------------------------------------------
module bcd_digit_cnt #(
    parameter int unsigned MAX = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic       max_override,
    output logic [3:0] q,
    output logic       carry
);

    localparam logic [3:0] MAX_Q = 4'(MAX);

    logic [3:0] r_q;
    logic       w_top;

    // Using >= means any out-of-range value also wraps to 0.
    assign w_top = (r_q >= MAX_Q) || max_override;
    assign carry = inc && w_top;
    assign q     = r_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_q <= 4'd0;
        end else if (inc) begin
            r_q <= w_top ? 4'd0 : r_q + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// ----------------------------------------------------------------------------
// stopwatch_bcd
// BCD stopwatch that drives an 8-digit display as HH MM SS cc.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   start_stop : pulse; IDLE/PAUSE -> RUN, RUN -> PAUSE
//   clear      : pulse; zero everything and return to IDLE
//   lap        : pulse; freeze or release the displayed value
//   digits     : 8 BCD nibbles, [31:28] = hour tens ... [3:0] = cs units
//   running    : high while in RUN
//   tick       : one-cycle pulse, aligned with each centisecond update
//
// state | meaning
// IDLE  | count zero, stopped
// RUN   | prescaler and cascade advancing
// PAUSE | stopped, count and prescaler phase retained
// ----------------------------------------------------------------------------
module stopwatch_bcd
    import stopwatch_bcd_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [31:0] digits,
    output logic        running,
    output logic        tick
);

    localparam int unsigned    PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

    state_t          r_state;
    logic [PW-1:0]   r_pre;
    logic            r_running;
    logic            r_tick;
    logic            r_lap_hold;
    logic [31:0]     r_lap;

    logic            w_tick;
    logic            w_hour_tc;
    logic [31:0]     w_live;
    logic [NUM_DIGITS-1:0] w_inc;
    logic [NUM_DIGITS-1:0] w_carry;

    assign w_tick    = (r_state == ST_RUN) && (r_pre == PRE_LAST);
    assign w_hour_tc = (w_live[31:24] == HOUR_TC);

    assign w_inc[0] = w_tick;
    assign w_inc[NUM_DIGITS-1:1] = w_carry[NUM_DIGITS-2:0];

    // clear goes straight to every digit, so a tick that arrives in the
    // same cycle as clear is discarded.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_cnt #(
            .MAX (DIGIT_MAX[i])
        ) u_cnt (
            .clk          (clk),
            .rst          (rst),
            .clr          (clear),
            .inc          (w_inc[i]),
            .max_override ((i == HOUR_UNITS_IDX) ? w_hour_tc : 1'b0),
            .q            (w_live[i*4 +: 4]),
            .carry        (w_carry[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state    <= ST_IDLE;
            r_pre      <= '0;
            r_running  <= 1'b0;
            r_tick     <= 1'b0;
            r_lap_hold <= 1'b0;
            r_lap      <= '0;
        end else begin
            r_tick <= w_tick;
            if (r_state == ST_RUN) begin
                r_pre <= w_tick ? '0 : r_pre + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start_stop) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN, ST_PAUSE: begin
                    if (start_stop) begin
                        r_state   <= (r_state == ST_RUN) ? ST_PAUSE : ST_RUN;
                        r_running <= (r_state != ST_RUN);
                    end else if (lap) begin
                        // w_live is sampled before this cycle's increment.
                        if (!r_lap_hold) begin
                            r_lap      <= w_live;
                            r_lap_hold <= 1'b1;
                        end else begin
                            r_lap_hold <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_running  <= 1'b0;
                    r_lap_hold <= 1'b0;
                end
            endcase
        end
    end

    assign digits  = r_lap_hold ? r_lap : w_live;
    assign running = r_running;
    assign tick    = r_tick;

endmodule
